// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, and emits the datapath strobes and retire count.
module core_sequencer #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic [2:0]  aluOp,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        halt_req,
    output logic        imemReq,
    output logic        irWrite,
    output logic        aluStart,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic        rfWrite,
    output logic        pcWrite,
    output logic        pcBranch,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b111;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  mul_cnt_q;
    logic        exec_first_q;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        mul_wait_s;
    logic        retire_s;
    state_e      ret_next_s;

    // Retire detection and post-retire destination.
    always_comb begin
        mul_wait_s = (aluOp == OP_MUL) && (mul_cnt_q != 4'd0);
        instret_d  = instret_q + 32'd1;
        if (halt_req) begin
            ret_next_s = S_HALT;
        end else begin
            ret_next_s = S_FETCH;
        end
        case (state_q)
            S_EXEC:  retire_s = !mul_wait_s && !(memRead || memWrite) && !regWrite;
            S_MEM:   retire_s = dmem_ready && !memRead;
            S_WB:    retire_s = 1'b1;
            default: retire_s = 1'b0;
        endcase
    end

    // Sequencer state, multiply countdown and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            mul_cnt_q    <= 4'd0;
            exec_first_q <= 1'b0;
            instret_q    <= 32'd0;
        end else begin
            exec_first_q <= 1'b0;
            if (retire_s) begin
                instret_q <= instret_d;
            end
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    mul_cnt_q    <= MUL_LOAD;
                    exec_first_q <= 1'b1;
                    state_q      <= S_EXEC;
                end
                S_EXEC: begin
                    if (mul_wait_s) begin
                        mul_cnt_q <= mul_cnt_q - 4'd1;
                    end else if (memRead || memWrite) begin
                        state_q <= S_MEM;
                    end else if (regWrite) begin
                        state_q <= S_WB;
                    end else begin
                        state_q <= ret_next_s;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_q <= memRead ? S_WB : ret_next_s;
                    end
                end
                S_WB: begin
                    state_q <= ret_next_s;
                end
                S_HALT: begin
                    if (!halt_req) begin
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes decode from state and handshakes; reset masks every one of them.
    always_comb begin
        imemReq  = !rst && (state_q == S_FETCH);
        irWrite  = !rst && (state_q == S_FETCH) && imem_ready;
        aluStart = !rst && (state_q == S_EXEC) && exec_first_q;
        dmemReq  = !rst && (state_q == S_MEM);
        dmemWe   = !rst && (state_q == S_MEM) && memWrite;
        rfWrite  = !rst && (state_q == S_WB) && regWrite && (aluOp != OP_NOP);
        pcWrite  = !rst && retire_s;
        pcBranch = !rst && retire_s && branch;
        halted   = !rst && (state_q == S_HALT);
        if (rst) begin
            state   = 3'd0;
            instret = 32'd0;
        end else begin
            state   = state_q;
            instret = instret_q;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: cycle-by-cycle state and strobe checks against
// hand-derived sequences, with a second instance at MUL_CYCLES=1.
module tb_core_sequencer;

    localparam logic [8:0] NONE = 9'b0_0000_0000;
    localparam logic [8:0] IMQ  = 9'b1_0000_0000;
    localparam logic [8:0] IRW  = 9'b0_1000_0000;
    localparam logic [8:0] ALS  = 9'b0_0100_0000;
    localparam logic [8:0] DMQ  = 9'b0_0010_0000;
    localparam logic [8:0] DWE  = 9'b0_0001_0000;
    localparam logic [8:0] RFW  = 9'b0_0000_1000;
    localparam logic [8:0] PCW  = 9'b0_0000_0100;
    localparam logic [8:0] PCB  = 9'b0_0000_0010;
    localparam logic [8:0] HLT  = 9'b0_0000_0001;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic        clk;
    logic        rst;
    logic        branch;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic [2:0]  aluOp;
    logic        imem_ready;
    logic        dmem_ready;
    logic        halt_req;

    logic        imemReq0, irWrite0, aluStart0, dmemReq0, dmemWe0;
    logic        rfWrite0, pcWrite0, pcBranch0, halted0;
    logic [2:0]  st0;
    logic [31:0] instret0;
    logic        imemReq1, irWrite1, aluStart1, dmemReq1, dmemWe1;
    logic        rfWrite1, pcWrite1, pcBranch1, halted1;
    logic [2:0]  st1;
    logic [31:0] instret1;

    logic [8:0]  strb0;
    logic [8:0]  strb1;

    int checks;
    int errors;

    assign strb0 = {imemReq0, irWrite0, aluStart0, dmemReq0, dmemWe0,
                    rfWrite0, pcWrite0, pcBranch0, halted0};
    assign strb1 = {imemReq1, irWrite1, aluStart1, dmemReq1, dmemWe1,
                    rfWrite1, pcWrite1, pcBranch1, halted1};

    core_sequencer #(.MUL_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .branch(branch), .memRead(memRead),
        .memWrite(memWrite), .regWrite(regWrite), .aluOp(aluOp),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .imemReq(imemReq0), .irWrite(irWrite0), .aluStart(aluStart0),
        .dmemReq(dmemReq0), .dmemWe(dmemWe0), .rfWrite(rfWrite0),
        .pcWrite(pcWrite0), .pcBranch(pcBranch0), .halted(halted0),
        .state(st0), .instret(instret0)
    );

    core_sequencer #(.MUL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .branch(branch), .memRead(memRead),
        .memWrite(memWrite), .regWrite(regWrite), .aluOp(aluOp),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .imemReq(imemReq1), .irWrite(irWrite1), .aluStart(aluStart1),
        .dmemReq(dmemReq1), .dmemWe(dmemWe1), .rfWrite(rfWrite1),
        .pcWrite(pcWrite1), .pcBranch(pcBranch1), .halted(halted1),
        .state(st1), .instret(instret1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp0(input string tag, input logic [2:0] st, input logic [8:0] sb);
        #1;
        chk_eq(tag, {20'd0, st0, strb0}, {20'd0, st, sb});
    endtask

    task automatic exp1(input string tag, input logic [2:0] st, input logic [8:0] sb);
        chk_eq(tag, {20'd0, st1, strb1}, {20'd0, st, sb});
    endtask

    // Directed stimulus; inputs change just after each rising edge.
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; branch = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        regWrite = 1'b0; aluOp = OP_ADD;
        imem_ready = 1'b1; dmem_ready = 1'b1; halt_req = 1'b1;

        tick(); exp0("rst_a", 3'd0, NONE); chk_eq("rst_a_instret", instret0, 32'd0);
        tick(); exp0("rst_b", 3'd0, NONE); exp1("rst_b_d1", 3'd0, NONE);

        // add, zero-wait
        tick(); rst = 1'b0; halt_req = 1'b0; regWrite = 1'b1;
        exp0("add_f", 3'd0, IMQ | IRW);
        tick(); exp0("add_d", 3'd1, NONE);
        tick(); exp0("add_e", 3'd2, ALS);
        tick(); exp0("add_wb", 3'd4, RFW | PCW);
        tick(); imem_ready = 1'b0; exp0("add_next", 3'd0, IMQ);
        chk_eq("add_instret", instret0, 32'd1);

        // lw with two dmem wait cycles
        tick(); memRead = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b1;
        exp0("lw_f", 3'd0, IMQ | IRW);
        tick(); imem_ready = 1'b0; exp0("lw_d", 3'd1, NONE);
        tick(); exp0("lw_e", 3'd2, ALS);
        tick(); exp0("lw_m1", 3'd3, DMQ);
        tick(); exp0("lw_m2", 3'd3, DMQ);
        tick(); dmem_ready = 1'b1; exp0("lw_m3", 3'd3, DMQ);
        tick(); dmem_ready = 1'b0; exp0("lw_wb", 3'd4, RFW | PCW);
        tick(); exp0("lw_next", 3'd0, IMQ);
        chk_eq("lw_instret", instret0, 32'd2);

        // sw taken-branch flag, one dmem wait, halt_req pulsed during fetch only
        tick(); memRead = 1'b0; memWrite = 1'b1; regWrite = 1'b0; branch = 1'b1;
        imem_ready = 1'b1; halt_req = 1'b1;
        exp0("sw_f", 3'd0, IMQ | IRW);
        tick(); imem_ready = 1'b0; halt_req = 1'b0; exp0("sw_d", 3'd1, NONE);
        tick(); exp0("sw_e", 3'd2, ALS);
        tick(); exp0("sw_m_wait", 3'd3, DMQ | DWE);
        tick(); dmem_ready = 1'b1; exp0("sw_m_done", 3'd3, DMQ | DWE | PCW | PCB);
        tick(); dmem_ready = 1'b0; exp0("sw_next", 3'd0, IMQ);
        chk_eq("sw_instret", instret0, 32'd3);

        // NOP op with regWrite, halt requested at retire
        tick(); memWrite = 1'b0; branch = 1'b0; regWrite = 1'b1; aluOp = OP_NOP;
        imem_ready = 1'b1;
        exp0("nop_f", 3'd0, IMQ | IRW);
        tick(); imem_ready = 1'b0; exp0("nop_d", 3'd1, NONE);
        tick(); exp0("nop_e", 3'd2, ALS);
        tick(); halt_req = 1'b1; exp0("nop_wb", 3'd4, PCW);
        tick(); imem_ready = 1'b1; exp0("halt_1", 3'd5, HLT);
        tick(); exp0("halt_2", 3'd5, HLT);
        tick(); halt_req = 1'b0; imem_ready = 1'b0; exp0("halt_drop", 3'd5, HLT);
        tick(); exp0("halt_exit", 3'd0, IMQ);
        chk_eq("halt_instret", instret0, 32'd4);

        // mul: 4-cycle EXEC on dut0, single-cycle EXEC on dut1
        tick(); aluOp = OP_MUL; imem_ready = 1'b1;
        exp0("mul_f", 3'd0, IMQ | IRW); exp1("mul1_f", 3'd0, IMQ | IRW);
        tick(); imem_ready = 1'b0;
        exp0("mul_d", 3'd1, NONE); exp1("mul1_d", 3'd1, NONE);
        tick(); exp0("mul_e1", 3'd2, ALS); exp1("mul1_e", 3'd2, ALS);
        tick(); exp0("mul_e2", 3'd2, NONE); exp1("mul1_wb", 3'd4, RFW | PCW);
        tick(); exp0("mul_e3", 3'd2, NONE); exp1("mul1_next", 3'd0, IMQ);
        tick(); exp0("mul_e4", 3'd2, NONE);
        tick(); exp0("mul_wb", 3'd4, RFW | PCW);
        tick(); exp0("mul_next", 3'd0, IMQ);
        chk_eq("mul_instret", instret0, 32'd5);
        chk_eq("mul1_instret", instret1, 32'd5);

        // reset while MEM waits, late dmem_ready afterwards
        tick(); aluOp = OP_ADD; memRead = 1'b1; imem_ready = 1'b1;
        exp0("rm_f", 3'd0, IMQ | IRW);
        tick(); imem_ready = 1'b0; exp0("rm_d", 3'd1, NONE);
        tick(); exp0("rm_e", 3'd2, ALS);
        tick(); exp0("rm_m", 3'd3, DMQ);
        tick(); rst = 1'b1; dmem_ready = 1'b1; exp0("rm_rst", 3'd0, NONE);
        chk_eq("rm_rst_instret", instret0, 32'd0);
        tick(); rst = 1'b0; memRead = 1'b0; regWrite = 1'b0;
        exp0("rm_rel", 3'd0, IMQ);
        chk_eq("rm_rel_instret", instret0, 32'd0);
        tick(); exp0("rm_late", 3'd0, IMQ);
        tick(); dmem_ready = 1'b0; exp0("rm_late2", 3'd0, IMQ);

        // reset mid-MUL with a nonzero retire count
        tick(); u_dut0.instret_q <= 32'h0000_0055; aluOp = OP_MUL; regWrite = 1'b1;
        imem_ready = 1'b1;
        exp0("rmul_f", 3'd0, IMQ | IRW);
        tick(); imem_ready = 1'b0; exp0("rmul_d", 3'd1, NONE);
        chk_eq("rmul_preload", instret0, 32'h0000_0055);
        tick(); exp0("rmul_e1", 3'd2, ALS);
        tick(); exp0("rmul_e2", 3'd2, NONE);
        tick(); rst = 1'b1; exp0("rmul_rst", 3'd0, NONE);
        tick(); rst = 1'b0; aluOp = OP_ADD; exp0("rmul_rel", 3'd0, IMQ);
        chk_eq("rmul_instret", instret0, 32'd0);

        // instret wrap
        tick(); u_dut0.instret_q <= 32'hFFFF_FFFF; imem_ready = 1'b1;
        exp0("wrap_f", 3'd0, IMQ | IRW);
        tick(); imem_ready = 1'b0; exp0("wrap_d", 3'd1, NONE);
        chk_eq("wrap_pre", instret0, 32'hFFFF_FFFF);
        tick(); exp0("wrap_e", 3'd2, ALS);
        tick(); exp0("wrap_wb", 3'd4, RFW | PCW);
        tick(); exp0("wrap_next", 3'd0, IMQ);
        chk_eq("wrap_instret", instret0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
